// File: rtl/nroot_pkg.sv
// Shared widths and state encoding for the nroot mantissa datapath.
// Root is 24 bits, the radicand 48 bits, and the trial subtractor 27 bits.
package nroot_pkg;

  localparam int ROOT_W  = 24;
  localparam int RAD_W   = 48;
  localparam int TRIAL_W = 27;

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    DONE
  } sqrt_state_t;

endpackage

// File: rtl/FS_24.sv
// 24-bit ripple full-subtractor: out = a - b - cin.
// cout is the borrow out of bit 23.
module FS_24 (
  input  logic [23:0] a,
  input  logic [23:0] b,
  input  logic        cin,
  output logic [23:0] out,
  output logic        cout
);

  always_comb begin : b_ripple
    logic w_bw;
    w_bw = cin;
    out  = '0;
    for (int i = 0; i < 24; i++) begin
      out[i] = a[i] ^ b[i] ^ w_bw;
      w_bw   = (~a[i] & b[i]) |
               (~(a[i] ^ b[i]) & w_bw);
    end
    cout = w_bw;
  end

endmodule

// File: rtl/fs_sqrt_iter.sv
// Sequential restoring square root, one root bit per clock.
// Returns floor(sqrt(rad_i)), the remainder and a sticky bit.
module fs_sqrt_iter
  import nroot_pkg::*;
#(
  parameter int N  = ROOT_W,
  parameter int RW = N + 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*N-1:0] rad_i,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N-1:0]   root_o,
  output logic [N:0]     rem_o,
  output logic           sticky_o
);

  localparam int CW = $clog2(N);
  localparam int HW = RW - 24;

  sqrt_state_t r_state;
  sqrt_state_t w_nxt;

  logic [2*N-1:0] r_sh;
  logic [N-1:0]   r_q;
  logic [N:0]     r_rem;
  logic [CW-1:0]  r_cnt;

  logic [RW-1:0]  w_m;
  logic [RW-1:0]  w_s;
  logic [RW-1:0]  w_diff;
  logic [23:0]    w_dlo;
  logic [HW-1:0]  w_dhi;
  logic           w_bw_lo;
  logic           w_borrow;
  logic           w_hi_unused;

  assign w_m = RW'({r_rem, r_sh[2*N-1 -: 2]});
  assign w_s = RW'({r_q, 2'b01});

  FS_24 u_fs (
    .a    (w_m[23:0]),
    .b    (w_s[23:0]),
    .cin  (1'b0),
    .out  (w_dlo),
    .cout (w_bw_lo)
  );

  // Borrow extension over the bits above the 24-bit subtractor
  always_comb begin : b_ext
    logic w_bw;
    w_bw  = w_bw_lo;
    w_dhi = '0;
    for (int i = 0; i < HW; i++) begin
      w_dhi[i] = w_m[24+i] ^ w_s[24+i] ^ w_bw;
      w_bw     = (~w_m[24+i] & w_s[24+i]) |
                 (~(w_m[24+i] ^ w_s[24+i]) & w_bw);
    end
    w_borrow = w_bw;
  end

  assign w_diff = {w_dhi, w_dlo};

  // Always zero on a successful trial since R <= 2Q
  assign w_hi_unused = |w_diff[RW-1:N+1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nxt;
    end
  end

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      IDLE: if (in_valid) w_nxt = ITER;
      ITER: if (r_cnt == '0) w_nxt = DONE;
      DONE: if (out_ready) w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sh  <= '0;
      r_q   <= '0;
      r_rem <= '0;
      r_cnt <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_sh  <= rad_i;
            r_q   <= '0;
            r_rem <= '0;
            r_cnt <= CW'(N - 1);
          end
        end
        ITER: begin
          r_sh  <= {r_sh[2*N-3:0], 2'b00};
          r_q   <= {r_q[N-2:0], ~w_borrow};
          r_rem <= w_borrow ? w_m[N:0]
                            : w_diff[N:0];
          r_cnt <= r_cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign root_o    = out_valid ? r_q : '0;
  assign rem_o     = out_valid ? r_rem : '0;
  assign sticky_o  = out_valid & (|r_rem);

endmodule
